// File: rtl/dcache_pkg.sv
// Shared types and address-split helpers for the direct-mapped write-through data cache.
package dcache_pkg;

  typedef enum logic {IDLE, REFILL} dcache_state_t;

  typedef enum logic [1:0] {ST_NONE, ST_B, ST_H, ST_W} store_size_t;

  function automatic int offset_width(input int words_per_line);
    return $clog2(words_per_line) + 2;
  endfunction

  function automatic int index_width(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_width(input int addr_len, input int lines, input int words_per_line);
    return addr_len - index_width(lines) - offset_width(words_per_line);
  endfunction

endpackage

// File: rtl/dcache_store_merge.sv
// Merges a byte/half/word store into a cached 32-bit word and flags stores that
// cross a word boundary (those must invalidate the line rather than merge).
module dcache_store_merge
  import dcache_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wd,
  input  logic [1:0]  byte_off,
  input  store_size_t size,
  output logic [31:0] merged,
  output logic        misaligned
);

  logic [3:0]  be;
  logic [31:0] src;

  always_comb begin
    be         = 4'b0000;
    misaligned = 1'b0;
    case (size)
      ST_B: be = 4'b0001 << byte_off;
      ST_H: begin
        be         = 4'b0011 << byte_off;
        misaligned = (byte_off == 2'd3);
      end
      ST_W: begin
        be         = 4'b1111 << byte_off;
        misaligned = (byte_off != 2'd0);
      end
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    src    = wd << {byte_off, 3'b000};
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[8*b +: 8] = src[8*b +: 8];
    end
  end

endmodule

// File: rtl/dcache_direct.sv
// Direct-mapped, write-through, no-write-allocate data cache with stalling line refill.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is defined.
module dcache_direct
  import dcache_pkg::*;
#(
  parameter int ADDRESS_LENGTH = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDRESS_LENGTH-1:0] cpu_a,
  input  logic [ADDRESS_LENGTH-1:0] cpu_wd,
  input  logic                      cpu_re,
  input  logic                      cpu_sw,
  input  logic                      cpu_sh,
  input  logic                      cpu_sb,
  output logic [ADDRESS_LENGTH-1:0] cpu_rd,
  output logic                      stall,
  output logic [ADDRESS_LENGTH-1:0] mem_a,
  output logic [ADDRESS_LENGTH-1:0] mem_wd,
  output logic                      mem_sw,
  output logic                      mem_sh,
  output logic                      mem_sb,
  input  logic [ADDRESS_LENGTH-1:0] mem_rd,
  output logic [31:0]               hit_count,
  output logic [31:0]               miss_count
);

  localparam int OW = offset_width(WORDS_PER_LINE);
  localparam int IW = index_width(LINES);
  localparam int TW = tag_width(ADDRESS_LENGTH, LINES, WORDS_PER_LINE);
  localparam int WW = OW - 2;

  logic [TW-1:0] tag;
  logic [IW-1:0] idx;
  logic [WW-1:0] woff;

  assign tag  = cpu_a[ADDRESS_LENGTH-1 -: TW];
  assign idx  = cpu_a[OW +: IW];
  assign woff = cpu_a[2 +: WW];

  dcache_state_t state;
  logic [WW-1:0] cnt;
  logic [TW-1:0] rf_tag;
  logic [IW-1:0] rf_idx;

  logic [LINES-1:0]          valid;
  logic [TW-1:0]             tag_mem  [LINES];
  logic [ADDRESS_LENGTH-1:0] data_mem [LINES][WORDS_PER_LINE];

  store_size_t st_size;
  logic        is_store;
  logic        is_load;
  logic        hit;
  logic        miss_det;
  logic        store_req;
  logic        refilling;
  logic [31:0] merged;
  logic        misaligned;

  // RAM resolves simultaneous strobes as sb > sh > sw; the merge must agree.
  always_comb begin
    st_size = ST_NONE;
    if (cpu_sb)      st_size = ST_B;
    else if (cpu_sh) st_size = ST_H;
    else if (cpu_sw) st_size = ST_W;
  end

  assign is_store  = (st_size != ST_NONE);
  assign is_load   = cpu_re && !is_store;
  assign hit       = valid[idx] && (tag_mem[idx] == tag);
  assign miss_det  = (state == IDLE) && is_load && !hit;
  assign store_req = (state == IDLE) && is_store;
  assign refilling = (state == REFILL);

  dcache_store_merge u_merge (
    .old_word  (data_mem[idx][woff]),
    .wd        (cpu_wd),
    .byte_off  (cpu_a[1:0]),
    .size      (st_size),
    .merged    (merged),
    .misaligned(misaligned)
  );

  assign cpu_rd = data_mem[idx][woff];
  assign mem_wd = cpu_wd;

  // Outputs are forced quiet while reset is held, even with a load still presented.
  assign stall  = rst_n && (miss_det || refilling);
  assign mem_sb = rst_n && store_req && cpu_sb;
  assign mem_sh = rst_n && store_req && cpu_sh;
  assign mem_sw = rst_n && store_req && cpu_sw;

  always_comb begin
    mem_a = '0;
    if (rst_n) begin
      if (refilling) mem_a = {rf_tag, rf_idx, cnt, 2'b00};
      else           mem_a = cpu_a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      valid  <= '0;
      rf_tag <= '0;
      rf_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_det) begin
            valid[idx] <= 1'b0;
            rf_tag     <= tag;
            rf_idx     <= idx;
            cnt        <= '0;
            state      <= REFILL;
          end else if (store_req && hit && misaligned) begin
            valid[idx] <= 1'b0;
          end
        end
        REFILL: begin
          cnt <= cnt + 1'b1;
          if (cnt == WW'(WORDS_PER_LINE - 1)) begin
            valid[rf_idx] <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (miss_det) tag_mem[idx] <= tag;
    if (refilling) data_mem[rf_idx][cnt] <= mem_rd;
    if (store_req && hit && !misaligned) data_mem[idx][woff] <= merged;
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hits;
  logic [31:0] misses;
  logic        load_hit;

  assign load_hit = (state == IDLE) && is_load && hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits   <= '0;
      misses <= '0;
    end else begin
      if (load_hit && (hits != 32'hFFFF_FFFF))   hits   <= hits + 32'd1;
      if (miss_det && (misses != 32'hFFFF_FFFF)) misses <= misses + 32'd1;
    end
  end

  assign hit_count  = hits;
  assign miss_count = misses;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_direct.sv
// Self-checking bench for dcache_direct: RAM stub, expected-data scoreboard, scenario tasks.
module tb_dcache_direct;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cpu_a, cpu_wd, cpu_rd;
  logic        cpu_re, cpu_sw, cpu_sh, cpu_sb;
  logic        stall;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        mem_sw, mem_sh, mem_sb;
  logic [31:0] hit_count, miss_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_hit  = 0;
  int exp_miss = 0;

  typedef struct {
    logic [31:0] data;
    int          stalls;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] ram     [256];
  logic [31:0] ref_mem [256];

  always #5 clk = ~clk;

  dcache_direct dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_a     (cpu_a),
    .cpu_wd    (cpu_wd),
    .cpu_re    (cpu_re),
    .cpu_sw    (cpu_sw),
    .cpu_sh    (cpu_sh),
    .cpu_sb    (cpu_sb),
    .cpu_rd    (cpu_rd),
    .stall     (stall),
    .mem_a     (mem_a),
    .mem_wd    (mem_wd),
    .mem_sw    (mem_sw),
    .mem_sh    (mem_sh),
    .mem_sb    (mem_sb),
    .mem_rd    (mem_rd),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [1:0] off, input int size);
    logic [3:0]  be;
    logic [31:0] src;
    logic [31:0] r;
    be  = (size == 1) ? 4'b0001 : (size == 2) ? 4'b0011 : 4'b1111;
    be  = be << off;
    src = wd << (8 * off);
    r   = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = src[8*b +: 8];
    return r;
  endfunction

  assign mem_rd = ram[mem_a[9:2]];

  always @(posedge clk) begin
    if (mem_sb)      ram[mem_a[9:2]] <= merge_word(ram[mem_a[9:2]], mem_wd, mem_a[1:0], 1);
    else if (mem_sh) ram[mem_a[9:2]] <= merge_word(ram[mem_a[9:2]], mem_wd, mem_a[1:0], 2);
    else if (mem_sw) ram[mem_a[9:2]] <= merge_word(ram[mem_a[9:2]], mem_wd, mem_a[1:0], 4);
  end

  task automatic do_load(input logic [31:0] addr, input bit miss, input bit chk_addr, input string name);
    exp_t        e;
    int          n;
    bit          done;
    logic [31:0] seen [8];
    logic [31:0] exp_a;
    e.data   = ref_mem[addr[9:2]];
    e.stalls = miss ? 5 : 0;
    sb_q.push_back(e);
    exp_hit++;
    if (miss) exp_miss++;
    @(posedge clk); #1;
    cpu_a  = addr;
    cpu_re = 1'b1;
    n    = 0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (stall) begin
        if (n < 8) seen[n] = mem_a;
        n++;
        n_checks++;
        if (mem_sb | mem_sh | mem_sw) begin
          n_fail++;
          $display("FAIL %s strobe_in_stall got=%b%b%b want=000", name, mem_sb, mem_sh, mem_sw);
        end
      end else begin
        done = 1'b1;
      end
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s timeout stall still high after 20 cycles", name);
    end
    e = sb_q.pop_front();
    n_checks++;
    if (cpu_rd !== e.data) begin
      n_fail++;
      $display("FAIL %s cpu_rd got=%h want=%h", name, cpu_rd, e.data);
    end
    n_checks++;
    if (n != e.stalls) begin
      n_fail++;
      $display("FAIL %s stall_cycles got=%0d want=%0d", name, n, e.stalls);
    end
    if (chk_addr && n == 5) begin
      for (int k = 0; k < 5; k++) begin
        exp_a = (k == 0) ? addr : ({addr[31:4], 4'b0000} + 32'(4 * (k - 1)));
        n_checks++;
        if (seen[k] !== exp_a) begin
          n_fail++;
          $display("FAIL %s refill_addr[%0d] got=%h want=%h", name, k, seen[k], exp_a);
        end
      end
    end
    @(posedge clk); #1;
    cpu_re = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] wd, input int size,
                          input bit also_re, input string name);
    logic [2:0] exp_s;
    exp_s = {size == 1, size == 2, size == 4};
    @(posedge clk); #1;
    cpu_a  = addr;
    cpu_wd = wd;
    cpu_sb = exp_s[2];
    cpu_sh = exp_s[1];
    cpu_sw = exp_s[0];
    cpu_re = also_re;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL %s stall got=%b want=0", name, stall);
    end
    n_checks++;
    if (mem_a !== addr || mem_wd !== wd) begin
      n_fail++;
      $display("FAIL %s mem_a/mem_wd got=%h/%h want=%h/%h", name, mem_a, mem_wd, addr, wd);
    end
    n_checks++;
    if ({mem_sb, mem_sh, mem_sw} !== exp_s) begin
      n_fail++;
      $display("FAIL %s strobes got=%b%b%b want=%b", name, mem_sb, mem_sh, mem_sw, exp_s);
    end
    ref_mem[addr[9:2]] = merge_word(ref_mem[addr[9:2]], wd, addr[1:0], size);
    @(posedge clk); #1;
    cpu_sb = 1'b0;
    cpu_sh = 1'b0;
    cpu_sw = 1'b0;
    cpu_re = 1'b0;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    cpu_a  = 32'h0000_5678;
    cpu_wd = '0;
    cpu_re = 1'b0;
    cpu_sb = 1'b0;
    cpu_sh = 1'b0;
    cpu_sw = 1'b0;
    #2;
    n_checks++;
    if (stall !== 1'b0 || {mem_sb, mem_sh, mem_sw} !== 3'b000 || mem_a !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got stall=%b strobes=%b%b%b mem_a=%h want 0", stall, mem_sb, mem_sh, mem_sw, mem_a);
    end
    n_checks++;
    if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_counters got=%0d/%0d want=0/0", hit_count, miss_count);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cpu_a = 32'h0000_1234;
    @(negedge clk);
    n_checks++;
    if (mem_a !== 32'h0000_1234 || stall !== 1'b0 || {mem_sb, mem_sh, mem_sw} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_passthru got mem_a=%h stall=%b want mem_a=00001234 stall=0", mem_a, stall);
    end
  endtask

  task automatic test_refill_hit();
    do_load(32'h0001_0000, 1'b1, 1'b1, "refill_first");
    do_load(32'h0001_0008, 1'b0, 1'b0, "hit_word2");
  endtask

  task automatic test_store_byte();
    do_store(32'h0001_0001, 32'h0000_00AB, 1, 1'b0, "sb_hit");
    do_load(32'h0001_0000, 1'b0, 1'b0, "load_after_sb");
  endtask

  task automatic test_store_miss();
    do_store(32'h0001_0040, 32'hDEAD_BEEF, 4, 1'b1, "sw_miss_with_re");
    do_load(32'h0001_0040, 1'b1, 1'b1, "load_after_sw_miss");
  endtask

  task automatic test_misaligned();
    do_load(32'h0001_0000, 1'b0, 1'b0, "pre_misaligned_hit");
    do_store(32'h0001_0003, 32'h0000_CDEF, 2, 1'b0, "sh_off3");
    do_load(32'h0001_0000, 1'b1, 1'b0, "load_after_invalidate");
  endtask

  task automatic test_reset_refill();
    @(posedge clk); #1;
    cpu_a  = 32'h0001_0020;
    cpu_re = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_refill_stall got=%b want=1", stall);
    end
    rst_n = 1'b0;
    exp_hit  = 0;
    exp_miss = 0;
    #1;
    n_checks++;
    if (stall !== 1'b0 || {mem_sb, mem_sh, mem_sw} !== 3'b000 || mem_a !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_refill got stall=%b strobes=%b%b%b mem_a=%h want 0", stall, mem_sb, mem_sh, mem_sw, mem_a);
    end
    @(negedge clk);
    cpu_re = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_load(32'h0001_0020, 1'b1, 1'b1, "refill_after_reset");
  endtask

  task automatic test_evict();
    do_load(32'h0001_0000, 1'b1, 1'b0, "evict_first");
    do_load(32'h0001_0100, 1'b1, 1'b1, "evict_second");
    do_load(32'h0001_0000, 1'b1, 1'b0, "evict_reload");
  endtask

  task automatic test_stats();
`ifdef DCACHE_STATS_EN
    n_checks++;
    if (hit_count !== 32'(exp_hit) || miss_count !== 32'(exp_miss)) begin
      n_fail++;
      $display("FAIL stats got=%0d/%0d want=%0d/%0d", hit_count, miss_count, exp_hit, exp_miss);
    end
`else
    n_checks++;
    if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
      n_fail++;
      $display("FAIL stats_tied got=%0d/%0d want=0/0", hit_count, miss_count);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'hC0DE_0000 | 32'(i);
    ram[0] = 32'h1111_1111;
    ram[1] = 32'h2222_2222;
    ram[2] = 32'h3333_3333;
    ram[3] = 32'h4444_4444;
    for (int i = 0; i < 256; i++) ref_mem[i] = ram[i];

    test_reset();
    test_refill_hit();
    test_store_byte();
    test_store_miss();
    test_misaligned();
    test_reset_refill();
    test_evict();
    test_stats();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_direct.md
Name: dcache_direct

Overview:
Direct-mapped, write-through, no-write-allocate data cache between the pipeline memory stage and the data RAM.
- Read hits return the aligned word in the same cycle.
- Read misses stall the pipeline while a multi-cycle line refill reads the RAM one word per cycle.
- Stores pass straight through to the RAM using its sb/sh/sw strobe convention, and update the cache on a hit.

Parameters:
ADDRESS_LENGTH, 32, address and data width
LINES, 16, number of cache lines (power of two)
WORDS_PER_LINE, 4, 32-bit words per line (power of two, >=2)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
cpu_a  input  ADDRESS_LENGTH  byte address from memory stage
cpu_wd  input  ADDRESS_LENGTH  store data (byte/half in low bits)
cpu_re  input  1  load request
cpu_sw, cpu_sh, cpu_sb  input  1 each  store-size strobes
cpu_rd  output  ADDRESS_LENGTH  word at cpu_a rounded down to a multiple of 4; valid when cpu_re=1 and stall=0
stall  output  1  freeze pipeline; cpu_* inputs must be held stable while high
mem_a  output  ADDRESS_LENGTH  RAM address
mem_wd  output  ADDRESS_LENGTH  RAM store data
mem_sw, mem_sh, mem_sb  output  1 each  RAM store strobes
mem_rd  input  ADDRESS_LENGTH  RAM combinational word read
hit_count, miss_count  output  32 each  statistics (see Optional Feature)

Behaviour:
- Address split: offset = log2(WORDS_PER_LINE)+2 low bits; index = next log2(LINES) bits; tag = remainder.
- Storage per line: valid bit, tag, WORDS_PER_LINE data words.
- Reset (rst_n low, asynchronous):
  - all valid bits 0, state IDLE, refill counter 0;
  - stall=0, mem_s* strobes=0, mem_a=0, counters 0.
- FSM states: IDLE, REFILL.
- IDLE, load (cpu_re=1, no store strobe):
  - Hit: cpu_rd = cached word, stall=0.
  - Miss: stall=1 combinationally; latch tag and write it to the tag entry; go to REFILL with cnt=0.
- REFILL:
  - mem_a = line base + 4*cnt.
  - mem_rd is written into data word cnt at the clock edge; cnt increments.
  - On cnt = WORDS_PER_LINE-1: set valid and return to IDLE.
  - stall=1 and all mem_s* strobes=0 throughout.
- Miss timing: stall is high for WORDS_PER_LINE+1 cycles (detect cycle + refill cycles); the next IDLE cycle hits and returns data.
- IDLE, store (any of cpu_sb/sh/sw):
  - mem_a=cpu_a, mem_wd=cpu_wd, strobes mirror cpu_s* in the same cycle; stall=0.
  - Strobe priority sb > sh > sw, matching the RAM.
  - Store hit: merge the affected bytes into the cached word.
  - Store miss: no allocation, cache unchanged.
- Misaligned store:
  - Halfword at offset 3, or word not a multiple of 4, crosses a word boundary.
  - Write-through still occurs; if the access hits, the line's valid bit is cleared.
- Load and store asserted together: store wins; load is ignored that cycle.
- No request: stall=0, strobes 0, mem_a=cpu_a.
- Reset mid-refill: refill aborts; the line stays invalid (valid is only set on the last word).
- Index wrap: lines with the same index evict each other. A refill overwrites the tag and all words regardless of the prior valid state.

Optional Feature:
DCACHE_STATS_EN
- Defined: hit_count increments on each IDLE load hit cycle; miss_count increments on each miss-detect cycle.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
  - Stores are not counted.
- Undefined: both outputs are tied to 0 and no counter flops are inferred.

Decomposition:
Package dcache_pkg holds:
- state enum dcache_state_t {IDLE, REFILL};
- store_size_t enum {ST_NONE, ST_B, ST_H, ST_W};
- localparam functions for offset/index/tag widths.

One sub-module, dcache_store_merge (combinational): inputs old word, cpu_wd, byte offset and store_size_t; outputs the merged word and a misaligned flag.

Test Plan:
1. RAM words 0x11111111,0x22222222,0x33333333,0x44444444 at 0x10000-0x1000C; after reset, load 0x10000.
   -> stall high 5 cycles; mem_a 0x10000,0x10004,0x10008,0x1000C; then cpu_rd=0x11111111, stall=0.
   -> Next: load 0x10008 -> 0x33333333 same cycle, stall=0.
2. With the line cached: sb 0x10001, wd=0x000000AB.
   -> Same cycle: mem_sb=1, mem_a=0x10001.
   -> Following load 0x10000 hits: 0x1111AB11.
3. sw 0x10040, wd=0xDEADBEEF, line not cached.
   -> No stall, strobe passes through.
   -> Following load 0x10040 misses and refills with cpu_rd=0xDEADBEEF.
4. Load 0x10000, then load 0x10100 (same index).
   -> Both miss, second evicts first.
   -> Load 0x10000 misses again with a 5-cycle stall.
5. Load miss at 0x10020; assert rst_n low during refill cycle 2.
   -> stall=0 and strobes=0 immediately.
   -> After release, load 0x10020 performs a full 5-cycle refill.
6. Line 0x10000 cached; sh 0x10003.
   -> mem_sh=1 written through; line invalidated; next load 0x10000 misses.
   -> With DCACHE_STATS_EN: counters match the hit/miss tally of the sequence.
